// File: rtl/svga_vram_pkg.sv
// Shared VRAM slot timing constants and CPU access state encoding for the SVGA video path.
package svga_vram_pkg;

   // Horizontal geometry of the SVGA timing generator
   localparam int unsigned H_ACTIVE     = 640;
   localparam int unsigned H_BORDER     = 64;
   localparam int unsigned DECODE_DELAY = 7;

   // Bus widths
   localparam int unsigned VRAM_ADDR_W = 13;
   localparam int unsigned PIX_W       = 11;
   localparam int unsigned PHASE_W     = 4;

   // Fetch window: decode pipeline runs DECODE_DELAY cycles ahead of the pixels it feeds
   localparam int unsigned SVGA_H_FETCH_START = H_BORDER - DECODE_DELAY;
   localparam int unsigned SVGA_H_FETCH_END   = H_ACTIVE - H_BORDER - DECODE_DELAY;
   localparam int unsigned SVGA_GUARD         = 3;

   // Slot phases inside one character/byte period
   localparam logic [PHASE_W-1:0] VID_ADDR  = PHASE_W'(0);
   localparam logic [PHASE_W-1:0] VID_LATCH = PHASE_W'(2);
   localparam logic [PHASE_W-1:0] VID_VALID = PHASE_W'(3);
   localparam logic [PHASE_W-1:0] CPU_FIRST = PHASE_W'(3);

   // CPU access sequencer states
   typedef enum logic [1:0] {
      CPU_IDLE = 2'd0,
      CPU_ADDR = 2'd1,
      CPU_RAM  = 2'd2,
      CPU_DONE = 2'd3
   } cpu_state_t;

   // Last phase of a period: 7 for the 8-clock period, 15 for the 16-clock period
   function automatic logic [PHASE_W-1:0] period_last(input logic wide);
      return wide ? PHASE_W'(7) : PHASE_W'(15);
   endfunction

endpackage

// File: rtl/vram_slot_phase.sv
// Fetch window decode, per-line period latch, slot phase counter and CPU start permission.
module vram_slot_phase
   import svga_vram_pkg::*;
#(
   parameter int unsigned H_FETCH_START = SVGA_H_FETCH_START,
   parameter int unsigned H_FETCH_END   = SVGA_H_FETCH_END,
   parameter int unsigned GUARD         = SVGA_GUARD
) (
   input  logic               i_pixel_clock,
   input  logic               i_reset,
   input  logic [PIX_W-1:0]   i_pixel_count,
   input  logic               i_show_line,
   input  logic               i_width_64,
   output logic               o_win_c,
   output logic [PHASE_W-1:0] o_phase_c,
   output logic               o_cpu_slot_c
);

   logic               r_wide;
   logic [PHASE_W-1:0] r_phase;

   logic               w_win;
   logic               w_guard;
   logic [PHASE_W-1:0] w_last;
   logic [PHASE_W-1:0] w_cpu_last;

   assign w_win = i_show_line
                  && (i_pixel_count >= PIX_W'(H_FETCH_START))
                  && (i_pixel_count <  PIX_W'(H_FETCH_END));

   // Quiet cycles before the first fetch so a CPU access cannot spill into phase 0
   assign w_guard = i_show_line
                    && (i_pixel_count >= PIX_W'(H_FETCH_START - GUARD))
                    && (i_pixel_count <  PIX_W'(H_FETCH_START));

   assign w_last     = period_last(r_wide);
   assign w_cpu_last = w_last - PHASE_W'(2);

   // Period latch follows width_64 outside the window; phase runs mod P inside it
   always_ff @(posedge i_pixel_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wide  <= 1'b0;
         r_phase <= '0;
      end else if (!w_win) begin
         r_wide  <= i_width_64;
         r_phase <= '0;
      end else if (r_phase == w_last) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + PHASE_W'(1);
      end
   end

   // Phase reads as 0 outside the window; CPU may start in the free middle slots or off-window
   always_comb begin
      o_win_c      = w_win;
      o_phase_c    = '0;
      o_cpu_slot_c = !w_guard;
      if (w_win) begin
         o_phase_c    = r_phase;
         o_cpu_slot_c = (r_phase >= CPU_FIRST) && (r_phase <= w_cpu_last);
      end
   end

endmodule

// File: rtl/vram_slot_arbiter.sv
// Time-division arbiter for the single-port VRAM: fixed video fetch slots, CPU in the gaps.
module vram_slot_arbiter
   import svga_vram_pkg::*;
#(
   parameter int unsigned ADDR_W        = VRAM_ADDR_W,
   parameter int unsigned H_FETCH_START = SVGA_H_FETCH_START,
   parameter int unsigned H_FETCH_END   = SVGA_H_FETCH_END,
   parameter int unsigned GUARD         = SVGA_GUARD
) (
   input  logic              pixel_clock,
   input  logic              reset,
   input  logic [PIX_W-1:0]  pixel_count,
   input  logic              show_line,
   input  logic              width_64,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [7:0]        vid_data,
   output logic              vid_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [7:0]        vram_wdata,
   input  logic [7:0]        vram_rdata
);

   // vid_valid is registered, so it is set in the phase before it is seen
   localparam logic [PHASE_W-1:0] VID_VALID_SET = VID_VALID - PHASE_W'(1);

   cpu_state_t         r_state;
   logic               r_cpu_we;
   logic [7:0]         r_vid_data;
   logic               r_vid_valid;
   logic [7:0]         r_cpu_rdata;
   logic               r_cpu_ack;
   logic [ADDR_W-1:0]  r_vram_addr;
   logic               r_vram_we;
   logic [7:0]         r_vram_wdata;

   logic               w_win;
   logic [PHASE_W-1:0] w_phase;
   logic               w_cpu_slot;
   logic               w_vid_slot;
   logic               w_cpu_start;

   vram_slot_phase #(
      .H_FETCH_START (H_FETCH_START),
      .H_FETCH_END   (H_FETCH_END),
      .GUARD         (GUARD)
   ) u_phase (
      .i_pixel_clock (pixel_clock),
      .i_reset       (reset),
      .i_pixel_count (pixel_count),
      .i_show_line   (show_line),
      .i_width_64    (width_64),
      .o_win_c       (w_win),
      .o_phase_c     (w_phase),
      .o_cpu_slot_c  (w_cpu_slot)
   );

   assign w_vid_slot  = w_win && (w_phase == VID_ADDR);
   assign w_cpu_start = cpu_req && (r_state == CPU_IDLE) && w_cpu_slot;

   // Video byte capture and its one-cycle strobe
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         r_vid_data  <= '0;
         r_vid_valid <= 1'b0;
      end else begin
         r_vid_valid <= w_win && (w_phase == VID_VALID_SET);
         if (w_win && (w_phase == VID_LATCH)) begin
            r_vid_data <= vram_rdata;
         end
      end
   end

   // CPU access sequencer and RAM port drive; the video address slot overrides last
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         r_state      <= CPU_IDLE;
         r_cpu_we     <= 1'b0;
         r_cpu_rdata  <= '0;
         r_cpu_ack    <= 1'b0;
         r_vram_addr  <= '0;
         r_vram_we    <= 1'b0;
         r_vram_wdata <= '0;
      end else begin
         r_cpu_ack <= 1'b0;
         case (r_state)
            CPU_IDLE: begin
               if (w_cpu_start) begin
                  r_state      <= CPU_ADDR;
                  r_cpu_we     <= cpu_we;
                  r_vram_addr  <= cpu_addr;
                  r_vram_we    <= cpu_we;
                  r_vram_wdata <= cpu_wdata;
               end
            end
            CPU_ADDR: begin
               r_state   <= CPU_RAM;
               r_vram_we <= 1'b0;
            end
            CPU_RAM: begin
               r_state   <= CPU_DONE;
               r_cpu_ack <= 1'b1;
               if (!r_cpu_we) begin
                  r_cpu_rdata <= vram_rdata;
               end
            end
            CPU_DONE: begin
               r_state <= CPU_IDLE;
            end
            default: begin
               r_state <= CPU_IDLE;
            end
         endcase
         if (w_vid_slot) begin
            r_vram_addr <= vid_addr;
            r_vram_we   <= 1'b0;
         end
      end
   end

   assign vid_data   = r_vid_data;
   assign vid_valid  = r_vid_valid;
   assign cpu_rdata  = r_cpu_rdata;
   assign cpu_ack    = r_cpu_ack;
   assign vram_addr  = r_vram_addr;
   assign vram_we    = r_vram_we;
   assign vram_wdata = r_vram_wdata;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: RAM model, line timing driver, video/CPU scoreboards.
module tb_vram_slot_arbiter;

   localparam int ADDR_W  = 13;
   localparam int H_TOTAL = 800;
   localparam int FS      = 57;
   localparam int FE      = 569;

   logic              pixel_clock;
   logic              reset;
   logic [10:0]       pixel_count;
   logic              show_line;
   logic              width_64;
   logic [ADDR_W-1:0] vid_addr;
   logic [7:0]        vid_data;
   logic              vid_valid;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ack;
   logic [ADDR_W-1:0] vram_addr;
   logic              vram_we;
   logic [7:0]        vram_wdata;
   logic [7:0]        vram_rdata;

   logic [7:0] mem     [0:8191];
   bit         written [0:8191];
   logic [7:0] shadow  [0:8191];
   logic [7:0] vid_q [$];
   logic [7:0] cpu_q [$];

   int n_asserts = 0;
   int n_fail    = 0;

   bit          m_wide;
   int          m_line_period;
   bit          line_active;
   int          strobe_cnt;
   bit          cpu_busy;
   int          we_cnt;
   logic [12:0] we_addr;
   logic [7:0]  we_data;

   vram_slot_arbiter dut (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .pixel_count (pixel_count),
      .show_line   (show_line),
      .width_64    (width_64),
      .vid_addr    (vid_addr),
      .vid_data    (vid_data),
      .vid_valid   (vid_valid),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ack     (cpu_ack),
      .vram_addr   (vram_addr),
      .vram_we     (vram_we),
      .vram_wdata  (vram_wdata),
      .vram_rdata  (vram_rdata)
   );

   initial begin
      pixel_clock = 1'b0;
      forever #5 pixel_clock = ~pixel_clock;
   end

   function automatic logic [7:0] init_pat(input logic [12:0] a);
      return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
   endfunction

   // Synchronous single-port RAM: data appears one cycle after the address cycle
   always @(posedge pixel_clock) begin
      if (vram_we) begin
         mem[vram_addr]     <= vram_wdata;
         written[vram_addr] <= 1'b1;
      end
      vram_rdata <= written[vram_addr] ? mem[vram_addr] : init_pat(vram_addr);
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (pixel_count=%0d, t=%0t)",
                  tag, got, exp, pixel_count, $time);
      end
   endtask

   // Per-cycle observation of the state produced by the cycle with the current pixel_count
   task automatic monitor();
      int pc;
      int per;
      int ph;
      int a;
      bit win;
      pc  = int'(pixel_count);
      if (reset) begin
         m_wide = 1'b0;
      end else begin
         win = show_line && (pc >= FS) && (pc < FE);
         per = m_wide ? 8 : 16;
         ph  = win ? (pc - FS) % per : 0;
         if (win && ph == 0) begin
            a = 'h100 + (pc - FS) / per;
            check_value("vid_addr", 32'(vram_addr), 32'(a));
            if (vram_we !== 1'b0) begin
               check_value("vid_slot_we", 32'(vram_we), 32'd0);
               $fatal(1, "video address slot overlapped a CPU access");
            end
            vid_q.push_back(shadow[a]);
         end
         check_value("vid_valid", 32'(vid_valid), 32'(win && ph == 2));
         if (vid_valid === 1'b1) begin
            strobe_cnt++;
            if (vid_q.size() == 0) check_value("vid_unexpected", 32'd1, 32'd0);
            else check_value("vid_data", 32'(vid_data), 32'(vid_q.pop_front()));
         end
         if (win && pc == FS) begin
            line_active   = 1'b1;
            m_line_period = per;
            strobe_cnt    = 0;
         end
         if (line_active && pc == 600) begin
            check_value("strobes_per_line", 32'(strobe_cnt), 32'(512 / m_line_period));
            line_active = 1'b0;
         end
         if (cpu_ack === 1'b1 && !cpu_busy) check_value("spurious_ack", 32'd1, 32'd0);
         if (vram_we === 1'b1) begin
            we_cnt++;
            we_addr = vram_addr;
            we_data = vram_wdata;
         end
         if (!win) m_wide = width_64;
      end
   endtask

   // One pixel: observe at the falling edge, then present the next pixel_count and fetch address
   task automatic tick();
      int pc;
      @(negedge pixel_clock);
      monitor();
      pixel_count = (pixel_count == 11'(H_TOTAL - 1)) ? 11'd0 : pixel_count + 11'd1;
      pc = int'(pixel_count);
      if (pc >= FS && pc < FE) vid_addr = 13'('h100 + (pc - FS) / (m_wide ? 8 : 16));
      else vid_addr = 13'h1FFF;
   endtask

   task automatic wait_pc(input int v);
      int n;
      n = 0;
      while (int'(pixel_count) != v && n < 2 * H_TOTAL) begin
         tick();
         n++;
      end
      check_value("wait_pc", 32'(pixel_count), 32'(v));
   endtask

   task automatic cpu_access(input logic we, input logic [12:0] addr, input logic [7:0] wdata,
                             input int exp_lat, input string tag);
      int lat;
      bit got;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_req   = 1'b1;
      cpu_busy  = 1'b1;
      we_cnt    = 0;
      if (we) shadow[addr] = wdata;
      else cpu_q.push_back(shadow[addr]);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         tick();
         lat++;
         if (cpu_ack === 1'b1) got = 1'b1;
      end
      cpu_req = 1'b0;
      check_value({tag, "_ack"}, 32'(got), 32'd1);
      check_value({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (!we) begin
         if (got) check_value({tag, "_rdata"}, 32'(cpu_rdata), 32'(cpu_q.pop_front()));
         else cpu_q.delete();
      end
      check_value({tag, "_we_cycles"}, 32'(we_cnt), 32'(we));
      if (we) begin
         check_value({tag, "_we_addr"}, 32'(we_addr), 32'(addr));
         check_value({tag, "_we_data"}, 32'(we_data), 32'(wdata));
      end
      cpu_we    = 1'b0;
      cpu_addr  = 13'h1ABC;
      cpu_wdata = 8'hFF;
      tick();
      check_value({tag, "_ack_pulse"}, 32'(cpu_ack), 32'd0);
      cpu_busy = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) shadow[i] = init_pat(13'(i));
      reset       = 1'b1;
      pixel_count = '0;
      show_line   = 1'b0;
      width_64    = 1'b1;
      vid_addr    = '0;
      cpu_req     = 1'b0;
      cpu_we      = 1'b0;
      cpu_addr    = '0;
      cpu_wdata   = '0;
      cpu_busy    = 1'b0;
      m_wide      = 1'b0;
      line_active = 1'b0;
      strobe_cnt  = 0;
      we_cnt      = 0;

      repeat (4) tick();
      check_value("rst_vid_data",   32'(vid_data),   32'd0);
      check_value("rst_vid_valid",  32'(vid_valid),  32'd0);
      check_value("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
      check_value("rst_cpu_ack",    32'(cpu_ack),    32'd0);
      check_value("rst_vram_addr",  32'(vram_addr),  32'd0);
      check_value("rst_vram_we",    32'(vram_we),    32'd0);
      check_value("rst_vram_wdata", 32'(vram_wdata), 32'd0);
      reset = 1'b0;

      // Line A: 8-clock periods, CPU write/read off-window
      wait_pc(700);
      show_line = 1'b1;
      wait_pc(10);
      cpu_access(1'b1, 13'h0123, 8'hA5, 3, "wr");
      cpu_access(1'b0, 13'h0123, 8'h00, 3, "rd");

      // Line B: 16-clock periods, requests at phase 0, P-3, P-2; width flip mid-line
      wait_pc(700);
      width_64 = 1'b0;
      wait_pc(FS + 16 * 4);
      cpu_access(1'b0, 13'h0040, 8'h00, 6, "ph0");
      wait_pc(FS + 16 * 6 + 13);
      cpu_access(1'b0, 13'h0041, 8'h00, 3, "ph_last");
      wait_pc(FS + 16 * 8 + 14);
      cpu_access(1'b0, 13'h0042, 8'h00, 8, "ph_late");
      wait_pc(300);
      width_64 = 1'b1;

      // Line C: 8-clock periods, request in the guard band and at period edges
      wait_pc(55);
      cpu_access(1'b1, 13'h0050, 8'h3C, 8, "guard");
      wait_pc(FS + 8 * 10 + 5);
      cpu_access(1'b0, 13'h0050, 8'h00, 3, "p8_last");
      wait_pc(FS + 8 * 12 + 6);
      cpu_access(1'b0, 13'h0051, 8'h00, 8, "p8_late");

      // Reset while a CPU write sits in the RAM cycle
      wait_pc(700);
      show_line = 1'b0;
      wait_pc(20);
      cpu_we    = 1'b1;
      cpu_addr  = 13'h0060;
      cpu_wdata = 8'hEE;
      cpu_req   = 1'b1;
      tick();
      check_value("mid_addr_we", 32'(vram_we), 32'd1);
      tick();
      reset = 1'b1;
      #1;
      check_value("mid_vid_data",   32'(vid_data),   32'd0);
      check_value("mid_vid_valid",  32'(vid_valid),  32'd0);
      check_value("mid_cpu_rdata",  32'(cpu_rdata),  32'd0);
      check_value("mid_cpu_ack",    32'(cpu_ack),    32'd0);
      check_value("mid_vram_addr",  32'(vram_addr),  32'd0);
      check_value("mid_vram_we",    32'(vram_we),    32'd0);
      check_value("mid_vram_wdata", 32'(vram_wdata), 32'd0);
      cpu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_value("mid_no_ack", 32'(cpu_ack), 32'd0);
      end
      reset = 1'b0;
      cpu_access(1'b1, 13'h0060, 8'hEE, 3, "reissue");
      cpu_access(1'b0, 13'h0060, 8'h00, 3, "reissue_rd");

      // Video resumes normally on the following line
      wait_pc(700);
      show_line = 1'b1;
      wait_pc(650);

      check_value("vid_q_empty", 32'(vid_q.size()), 32'd0);
      check_value("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
- Time-division arbiter for the single-port video RAM.
- Shared between the character/graphics fetch pipeline (decode phases 1–3: latch address, read, latch data) and the Z80 bus.
- Video fetches get fixed, guaranteed slots inside each character/byte period, derived from the pixel and line counters.
- CPU accesses are granted only in the remaining free slots, with a req/ack handshake that drives the CPU wait logic.

Parameters:
- ADDR_W, 13, VRAM address width (8 KB covers all text and graphics modes).
- H_FETCH_START, 57, pixel_count value of the first video fetch slot (64 border minus 7-cycle decode delay).
- H_FETCH_END, 569, first pixel_count after the last fetch period (640-64-7).
- GUARD, 3, cycles before H_FETCH_START in which no new CPU access may start.

Ports:
- pixel_clock  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_count  in  11  horizontal counter from the timing generator.
- show_line  in  1  high on active text/graphics lines.
- width_64  in  1  1: 8-clock fetch period (64 columns); 0: 16-clock period.
- vid_addr  in  ADDR_W  address of the next character/graphics byte.
- vid_data  out  8  latched video byte.
- vid_valid  out  1  one-cycle strobe, vid_data updated.
- cpu_req  in  1  level request, held until ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- vram_addr  out  ADDR_W  registered RAM address.
- vram_we  out  1  registered RAM write enable.
- vram_wdata  out  8  registered RAM write data.
- vram_rdata  in  8  synchronous RAM read data, valid one cycle after the address cycle.

Behaviour:
- Reset: all outputs 0; phase=0; cpu FSM in IDLE; period latch = 16.
- Window: win = show_line && H_FETCH_START <= pixel_count < H_FETCH_END.
- Period P: 8 if width_64, else 16. width_64 is latched only while win=0; changes inside a line take effect from the next line.
- Phase counter:
  - phase=0 on the cycle pixel_count==H_FETCH_START, then increments mod P.
  - Held at 0 while win=0.
- Video slot (video always has priority):
  - phase 0: vram_addr<=vid_addr, vram_we=0.
  - phase 1: RAM read cycle; address held.
  - phase 2: vid_data<=vram_rdata.
  - phase 3: vid_valid=1 for one cycle.
- CPU start permitted when cpu_req=1, FSM is IDLE, and one of:
  - win=1 and 3 <= phase <= P-3;
  - win=0 and pixel_count is not in [H_FETCH_START-GUARD, H_FETCH_START-1] (the guard applies only when show_line=1).
- CPU FSM:
  - IDLE -> ADDR (vram_addr<=cpu_addr; vram_we<=cpu_we; vram_wdata<=cpu_wdata)
  - ADDR -> RAM (write commits on this cycle; vram_we then cleared)
  - RAM -> DONE (cpu_rdata<=vram_rdata for reads; cpu_ack=1)
  - DONE -> IDLE.
  - Consequence: at most one access per 4 cycles; cpu_req must drop in the cycle after ack, otherwise a second access starts.
- Latency: CPU ack comes 3 cycles after a permitted start. Worst-case wait ≈ 6 cycles when width_64=1; the longest wait is the line guard.
- Window end: a CPU access in progress completes normally; the video slot is not restarted after H_FETCH_END.
- Simultaneous video phase 0 and CPU in ADDR/RAM cannot occur by construction. The bench asserts this and flags it as a fatal error.
- Reset mid-access: FSM returns to IDLE, no ack, vram_we drops immediately. A partial write is permitted; the CPU reissues it.
- cpu_addr/cpu_we/cpu_wdata are sampled only on the IDLE->ADDR transition.

Decomposition:
- Shared package svga_vram_pkg: CPU FSM state encoding (IDLE/ADDR/RAM/DONE), slot phase constants (VID_ADDR=0, VID_LATCH=2, VID_VALID=3, CPU_FIRST=3), and H_FETCH_START/H_FETCH_END derived from the SVGA H_ACTIVE and border defines.
- One natural sub-module, vram_slot_phase: window decode, period latch, phase counter and start-permission logic. Arbitration and the CPU FSM stay in the top module.

Test Plan:
- Video only, width_64=1, show_line=1, vid_addr=0x0100+n: vram_addr=vid_addr at every phase 0 (pixel_count 57, 65, …); vid_valid at phase 3; vid_data=RAM[vid_addr]; 64 strobes per line.
- CPU write 0xA5 to 0x0123 with win=0, pixel_count=10: vram_we high for exactly 1 cycle with addr 0x0123; cpu_ack 3 cycles after req; a subsequent read returns 0xA5.
- CPU req at phase 0 of a 16-clock period: start deferred to phase 3; ack at phase 6; the next video phase-0 address is unaffected.
- CPU req at pixel_count=55 on an active line: start deferred into the first free slot (phase 3 of the first period); no vram_addr conflict at pixel_count 57.
- Toggle width_64 mid-line: period stays 16 until the line ends; the next line uses 8.
- Assert reset during CPU state RAM: no ack, vram_we=0, all outputs 0; normal operation resumes after release.
